// File: rtl/cache_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// cache_cmd_scheduler
//
// Sequencer between the trace-command source and the split L1 caches.
// Accepts one command at a time (valid/ready), then steps the selected cache
// through a read phase (LOOKUP) and an update phase (UPDATE), runs the
// multi-cycle clear sweep, raises the print strobe and flags illegal opcodes.
// Hit/miss/read/write statistics are kept for the print command.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready   : command handshake; ready only in IDLE and out of reset
//   cmd_n, cmd_addr   : trace opcode and address, latched on accept
//   hit               : tag match from the selected cache, sampled on LOOKUP exit
//   sel_d, sel_i      : data / instruction cache select
//   read_enable       : cache read phase
//   write_enable      : cache update phase (also every cycle of the clear sweep)
//   lru_start         : LRU counter start strobe (UPDATE)
//   set_index, tag    : set under access and tag of the latched address
//   op_out            : latched opcode for the MESI FSM
//   clear_active      : clear sweep in progress
//   print_req, done   : print strobe, one-cycle completion pulse
//   err_unknown       : one-cycle pulse for an illegal opcode
//   stat_*            : saturating 32-bit statistics
// -----------------------------------------------------------------------------
module cache_cmd_scheduler #(
   parameter int SETS     = 16384,
   parameter int INDEX_W  = 14,
   parameter int OFFSET_W = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [3:0]                      cmd_n,
   input  logic [31:0]                     cmd_addr,
   input  logic                            hit,
   output logic                            sel_d,
   output logic                            sel_i,
   output logic                            read_enable,
   output logic                            write_enable,
   output logic                            lru_start,
   output logic [INDEX_W-1:0]              set_index,
   output logic [32-INDEX_W-OFFSET_W-1:0]  tag,
   output logic [3:0]                      op_out,
   output logic                            clear_active,
   output logic                            print_req,
   output logic                            done,
   output logic                            err_unknown,
   output logic [31:0]                     stat_reads,
   output logic [31:0]                     stat_writes,
   output logic [31:0]                     stat_hits,
   output logic [31:0]                     stat_misses
);

   localparam int TAG_W = 32 - INDEX_W - OFFSET_W;
   localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_UPDATE = 3'd2,
      ST_CLEAR  = 3'd3,
      ST_PRINT  = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [3:0]           op_r;
   logic [INDEX_W-1:0]   index_r;
   logic [TAG_W-1:0]     tag_r;
   logic [INDEX_W-1:0]   sweep_r;
   logic [31:0]          reads_r;
   logic [31:0]          writes_r;
   logic [31:0]          hits_r;
   logic [31:0]          misses_r;
   logic                 accept_s;
   logic                 sweep_last_s;
   logic                 unused_offset_s;

   // Byte-offset bits never affect the set or tag.
   assign unused_offset_s = ^cmd_addr[OFFSET_W-1:0];

   // Opcodes handled by the data cache lookup/update path.
   function automatic logic is_data_op(input logic [3:0] op);
      return (op == 4'd0) || (op == 4'd1) || (op == 4'd3) || (op == 4'd4);
   endfunction

   // First state after accepting an opcode.
   function automatic state_t entry_state(input logic [3:0] op);
      state_t st;
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4: st = ST_LOOKUP;
         4'd8:                         st = ST_CLEAR;
         4'd9:                         st = ST_PRINT;
         default:                      st = ST_ERR;
      endcase
      return st;
   endfunction

   // Counter increment that sticks at all-ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      logic [31:0] r;
      if (v == 32'hFFFF_FFFF) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

   assign cmd_ready    = (state_r == ST_IDLE) && !rst;
   assign accept_s     = cmd_valid && cmd_ready;
   assign sweep_last_s = (sweep_r == LAST_SET);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = entry_state(cmd_n);
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOOKUP: state_s = ST_UPDATE;
         ST_UPDATE: state_s = ST_IDLE;
         ST_CLEAR: begin
            if (sweep_last_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_CLEAR;
            end
         end
         ST_PRINT:  state_s = ST_IDLE;
         ST_ERR:    state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Command latch: opcode, set index and tag captured on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r    <= 4'd0;
         index_r <= '0;
         tag_r   <= '0;
      end else if (accept_s) begin
         op_r    <= cmd_n;
         index_r <= cmd_addr[OFFSET_W +: INDEX_W];
         tag_r   <= cmd_addr[31 -: TAG_W];
      end
   end

   // Clear sweep index: advances one set per CLEAR cycle, zero elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sweep_r <= '0;
      end else if ((state_r == ST_CLEAR) && !sweep_last_s) begin
         sweep_r <= sweep_r + {{(INDEX_W-1){1'b0}}, 1'b1};
      end else begin
         sweep_r <= '0;
      end
   end

   // Statistics: zeroed on clear entry, updated on the LOOKUP->UPDATE edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reads_r  <= 32'd0;
         writes_r <= 32'd0;
         hits_r   <= 32'd0;
         misses_r <= 32'd0;
      end else if (accept_s && (cmd_n == 4'd8)) begin
         reads_r  <= 32'd0;
         writes_r <= 32'd0;
         hits_r   <= 32'd0;
         misses_r <= 32'd0;
      end else if ((state_r == ST_LOOKUP) && (op_r <= 4'd2)) begin
         if (op_r == 4'd1) begin
            writes_r <= sat_inc(writes_r);
         end else begin
            reads_r  <= sat_inc(reads_r);
         end
         if (hit) begin
            hits_r   <= sat_inc(hits_r);
         end else begin
            misses_r <= sat_inc(misses_r);
         end
      end
   end

   // Moore output decode from state and the latched command.
   always_comb begin
      sel_d        = 1'b0;
      sel_i        = 1'b0;
      read_enable  = 1'b0;
      write_enable = 1'b0;
      lru_start    = 1'b0;
      clear_active = 1'b0;
      print_req    = 1'b0;
      done         = 1'b0;
      err_unknown  = 1'b0;
      case (state_r)
         ST_LOOKUP: begin
            read_enable = 1'b1;
            sel_d       = is_data_op(op_r);
            sel_i       = (op_r == 4'd2);
         end
         ST_UPDATE: begin
            write_enable = 1'b1;
            lru_start    = 1'b1;
            done         = 1'b1;
            sel_d        = is_data_op(op_r);
            sel_i        = (op_r == 4'd2);
         end
         ST_CLEAR: begin
            sel_d        = 1'b1;
            sel_i        = 1'b1;
            write_enable = 1'b1;
            clear_active = 1'b1;
            done         = sweep_last_s;
         end
         ST_PRINT: begin
            print_req = 1'b1;
            done      = 1'b1;
         end
         ST_ERR: begin
            err_unknown = 1'b1;
            done        = 1'b1;
         end
         default: begin
            done = 1'b0;
         end
      endcase
      if (state_r == ST_CLEAR) begin
         set_index = sweep_r;
      end else begin
         set_index = index_r;
      end
   end

   assign tag         = tag_r;
   assign op_out      = op_r;
   assign stat_reads  = reads_r;
   assign stat_writes = writes_r;
   assign stat_hits   = hits_r;
   assign stat_misses = misses_r;

endmodule

// File: tb/tb_cache_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cache_cmd_scheduler
//
// Scoreboard bench: the driver issues commands and pushes the expected
// completion (computed from the opcode rules) into a queue; a monitor on the
// falling edge checks LOOKUP cycles, the clear sweep and every done pulse.
// Uses an 8-set configuration so the clear sweep is short.
// -----------------------------------------------------------------------------
module tb_cache_cmd_scheduler;

   localparam int SETS     = 8;
   localparam int INDEX_W  = 3;
   localparam int OFFSET_W = 6;
   localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                cmd_valid = 1'b0;
   logic                cmd_ready;
   logic [3:0]          cmd_n = 4'd0;
   logic [31:0]         cmd_addr = 32'd0;
   logic                hit = 1'b0;
   logic                sel_d, sel_i, read_enable, write_enable, lru_start;
   logic [INDEX_W-1:0]  set_index;
   logic [TAG_W-1:0]    tag;
   logic [3:0]          op_out;
   logic                clear_active, print_req, done, err_unknown;
   logic [31:0]         stat_reads, stat_writes, stat_hits, stat_misses;

   cache_cmd_scheduler #(.SETS(SETS), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_n(cmd_n), .cmd_addr(cmd_addr), .hit(hit),
      .sel_d(sel_d), .sel_i(sel_i), .read_enable(read_enable),
      .write_enable(write_enable), .lru_start(lru_start),
      .set_index(set_index), .tag(tag), .op_out(op_out),
      .clear_active(clear_active), .print_req(print_req), .done(done),
      .err_unknown(err_unknown), .stat_reads(stat_reads),
      .stat_writes(stat_writes), .stat_hits(stat_hits), .stat_misses(stat_misses)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]         op;
      logic [INDEX_W-1:0] idx;
      logic [TAG_W-1:0]   tg;
      bit                 normal;
      bit                 sd, si, we, lru, pr, er, ca;
      logic [31:0]        r, w, h, m;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          pushes = 0;
   int          accepts = 0;
   int          dones = 0;
   int          dropped = 0;
   int          sweep_exp = 0;
   logic [31:0] m_r = 32'd0, m_w = 32'd0, m_h = 32'd0, m_m = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Reference model: expected state at the done pulse, and stats bookkeeping.
   function automatic exp_t predict(input logic [3:0] op, input logic [31:0] addr, input logic hv);
      exp_t e;
      e.op  = op;
      e.idx = INDEX_W'((addr >> OFFSET_W) % SETS);
      e.tg  = TAG_W'(addr >> (32 - TAG_W));
      e.normal = 1'b0;
      e.sd = 0; e.si = 0; e.we = 0; e.lru = 0; e.pr = 0; e.er = 0; e.ca = 0;
      if (op == 4'd8) begin
         m_r = 32'd0; m_w = 32'd0; m_h = 32'd0; m_m = 32'd0;
         e.sd = 1; e.si = 1; e.we = 1; e.ca = 1;
         e.idx = INDEX_W'(SETS - 1);
      end else if (op == 4'd9) begin
         e.pr = 1;
      end else if (op <= 4'd4) begin
         e.normal = 1'b1;
         e.we = 1; e.lru = 1;
         if (op == 4'd2) e.si = 1; else e.sd = 1;
         if (op <= 4'd2) begin
            if (op == 4'd1) m_w = sat(m_w); else m_r = sat(m_r);
            if (hv) m_h = sat(m_h); else m_m = sat(m_m);
         end
      end else begin
         e.er = 1;
      end
      e.r = m_r; e.w = m_w; e.h = m_h; e.m = m_m;
      return e;
   endfunction

   // Falling-edge samples counted from accept until cmd_ready is seen again.
   function automatic int lat_for(input logic [3:0] op);
      if (op <= 4'd4) return 3;
      if (op == 4'd8) return SETS + 1;
      return 2;
   endfunction

   // Issue one command; caller is at a falling edge. With hold, cmd_valid
   // stays high (same command) while the scheduler is busy.
   task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic hv, input bit hold);
      int n;
      int lat;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("ready_wait_timeout", 64'd0, 64'd1);
      cmd_n = op; cmd_addr = addr; hit = hv; cmd_valid = 1'b1;
      @(posedge clk);
      sb_q.push_back(predict(op, addr, hv));
      pushes++;
      #1;
      if (!hold) cmd_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!cmd_ready && lat < SETS + 20);
      check("ready_latency", 64'(lat), 64'(lat_for(op)));
      cmd_valid = 1'b0;
   endtask

   // Accept counter, sampled between edges.
   always begin
      bit pend;
      @(negedge clk);
      #1;
      pend = cmd_valid && cmd_ready;
      @(posedge clk);
      if (pend) accepts++;
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (read_enable || write_enable)
         check("re_we_exclusive", 64'(read_enable & write_enable), 64'd0);
      if (read_enable) begin
         if (sb_q.size() == 0) begin
            check("lookup_unexpected", 64'd1, 64'd0);
         end else begin
            check("lookup_sel_d", 64'(sel_d), 64'(sb_q[0].sd));
            check("lookup_sel_i", 64'(sel_i), 64'(sb_q[0].si));
            check("lookup_set_index", 64'(set_index), 64'(sb_q[0].idx));
            check("lookup_tag", 64'(tag), 64'(sb_q[0].tg));
            check("lookup_done", 64'(done), 64'd0);
         end
      end
      if (clear_active) begin
         check("clear_set_index", 64'(set_index), 64'(sweep_exp));
         sweep_exp++;
      end else begin
         sweep_exp = 0;
      end
      if (done) begin
         dones++;
         if (sb_q.size() == 0) begin
            check("done_unexpected", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("done_op_out", 64'(op_out), 64'(e.op));
            check("done_write_enable", 64'(write_enable), 64'(e.we));
            check("done_read_enable", 64'(read_enable), 64'd0);
            check("done_lru_start", 64'(lru_start), 64'(e.lru));
            check("done_print_req", 64'(print_req), 64'(e.pr));
            check("done_err_unknown", 64'(err_unknown), 64'(e.er));
            check("done_clear_active", 64'(clear_active), 64'(e.ca));
            check("done_sel_d", 64'(sel_d), 64'(e.sd));
            check("done_sel_i", 64'(sel_i), 64'(e.si));
            check("stat_reads", 64'(stat_reads), 64'(e.r));
            check("stat_writes", 64'(stat_writes), 64'(e.w));
            check("stat_hits", 64'(stat_hits), 64'(e.h));
            check("stat_misses", 64'(stat_misses), 64'(e.m));
            if (e.normal || e.ca) check("done_set_index", 64'(set_index), 64'(e.idx));
            if (e.normal) check("done_tag", 64'(tag), 64'(e.tg));
         end
      end
   end

   initial begin
      #(2_000_000);
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [3:0] op;
      int         r;

      // Reset state
      #3;
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_outputs", 64'({sel_d, sel_i, read_enable, write_enable, lru_start,
                                clear_active, print_req, done, err_unknown}), 64'd0);
      check("rst_set_index", 64'(set_index), 64'd0);
      check("rst_tag", 64'(tag), 64'd0);
      check("rst_op_out", 64'(op_out), 64'd0);
      check("rst_stats", 64'(stat_reads | stat_writes | stat_hits | stat_misses), 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(cmd_ready), 64'd1);

      // Directed: data read miss, instruction fetch hit
      issue(4'd0, 32'h984D_E132, 1'b0, 1'b0);
      issue(4'd2, 32'h116D_E12F, 1'b1, 1'b0);

      // Back-to-back with cmd_valid held
      issue(4'd1, 32'hDEAD_BEEF, 1'b1, 1'b1);
      issue(4'd0, 32'h0000_0FC0, 1'b0, 1'b1);
      issue(4'd4, 32'h1234_5678, 1'b1, 1'b1);

      // Illegal then print
      issue(4'd5, 32'hAAAA_5555, 1'b1, 1'b0);
      issue(4'd9, 32'h5555_AAAA, 1'b0, 1'b0);

      // Full clear sweep
      issue(4'd8, 32'h0000_0000, 1'b0, 1'b0);
      issue(4'd0, 32'h0000_0040, 1'b1, 1'b0);

      // Reset in the middle of a sweep
      cmd_n = 4'd8; cmd_addr = 32'h0; cmd_valid = 1'b1;
      @(posedge clk);
      sb_q.push_back(predict(4'd8, 32'h0, 1'b0));
      pushes++;
      #1 cmd_valid = 1'b0;
      r = 0;
      do begin
         @(negedge clk);
         r++;
      end while (!(clear_active && set_index == INDEX_W'(4)) && r < 50);
      if (r >= 50) check("sweep_idx4_timeout", 64'd0, 64'd1);
      #1 rst = 1'b1;
      #1;
      check("midrst_outputs", 64'({sel_d, sel_i, read_enable, write_enable, lru_start,
                                   clear_active, print_req, done, err_unknown}), 64'd0);
      check("midrst_set_index", 64'(set_index), 64'd0);
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
      sb_q.delete();
      dropped++;
      m_r = 32'd0; m_w = 32'd0; m_h = 32'd0; m_m = 32'd0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_midrst", 64'(cmd_ready), 64'd1);
      issue(4'd0, 32'h984D_E132, 1'b1, 1'b0);

      // Randomized commands
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 19);
         if (r < 13) begin
            op = 4'($urandom_range(0, 4));
         end else if (r < 15) begin
            op = 4'd9;
         end else if (r < 16) begin
            op = 4'd8;
         end else begin
            do op = 4'($urandom_range(5, 15)); while (op == 4'd8 || op == 4'd9);
         end
         issue(op, $urandom, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      check("accept_count", 64'(accepts), 64'(pushes));
      check("done_count", 64'(dones), 64'(pushes - dropped));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
